// File: rtl/can_rx_fifo.sv
// rtl/can_rx_fifo.sv - CAN receive message FIFO between the acceptance filter and the host read port
// Optional watermark flag: define RX_FIFO_WMARK_EN to add i_wmark_lvl / o_rx_wmark.
module can_rx_fifo #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_sys_clk,
  input  logic              i_reset,
  input  logic              i_rx_w_en,
  input  logic [DATA_W-1:0] i_rx_fifo_w_data,
  output logic              o_rx_full,
  output logic              o_rx_empty,
  output logic [ADDR_W:0]   o_rx_count,
  input  logic              i_rx_r_en,
  output logic [DATA_W-1:0] o_rx_r_data,
  output logic              o_rx_r_valid,
  output logic              o_rx_ok,
  input  logic              i_ovfl_clr,
`ifdef RX_FIFO_WMARK_EN
  input  logic [ADDR_W:0]   i_wmark_lvl,
  output logic              o_rx_wmark,
`endif
  output logic              o_rx_ovfl
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic              rd_acc;
  logic              wr_acc;
  logic              wr_drop;

  // A write into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  always_comb begin
    rd_acc  = i_rx_r_en & (count != '0);
    wr_acc  = i_rx_w_en & ((count != FULL_CNT) | rd_acc);
    wr_drop = i_rx_w_en & ~wr_acc;
  end

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Message storage; contents intentionally survive reset.
  always_ff @(posedge i_sys_clk) begin
    if (wr_acc) begin
      mem[wptr] <= i_rx_fifo_w_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_sys_clk or negedge i_reset) begin
    if (!i_reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      count <= count_nxt;
    end
  end

  // Registered read port; data holds its last value when no pop is accepted.
  always_ff @(posedge i_sys_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_rx_r_data  <= '0;
      o_rx_r_valid <= 1'b0;
    end else begin
      o_rx_r_valid <= rd_acc;
      if (rd_acc) o_rx_r_data <= mem[rptr];
    end
  end

  // Status pulses and sticky overflow; a drop wins over a same-cycle clear.
  always_ff @(posedge i_sys_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_rx_ok   <= 1'b0;
      o_rx_ovfl <= 1'b0;
    end else begin
      o_rx_ok <= wr_acc;
      if (wr_drop)         o_rx_ovfl <= 1'b1;
      else if (i_ovfl_clr) o_rx_ovfl <= 1'b0;
    end
  end

`ifdef RX_FIFO_WMARK_EN
  // Watermark tracks the next-state count so it lines up with o_rx_count; level 0 disables it.
  always_ff @(posedge i_sys_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_rx_wmark <= 1'b0;
    end else begin
      o_rx_wmark <= (i_wmark_lvl != '0) && (count_nxt >= i_wmark_lvl);
    end
  end
`endif

  assign o_rx_full  = (count == FULL_CNT);
  assign o_rx_empty = (count == '0);
  assign o_rx_count = count;

endmodule

// File: tb/tb_can_rx_fifo.sv
// tb/tb_can_rx_fifo.sv - self-checking bench for can_rx_fifo at DEPTH=4
module tb_can_rx_fifo;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 2;

  logic              clk;
  logic              rst_n;
  logic              w_en;
  logic [DATA_W-1:0] w_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              r_en;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              ok;
  logic              ovfl;
  logic              ovfl_clr;
`ifdef RX_FIFO_WMARK_EN
  logic [ADDR_W:0]   wmark_lvl;
  logic              wmark;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  can_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .i_sys_clk        (clk),
    .i_reset          (rst_n),
    .i_rx_w_en        (w_en),
    .i_rx_fifo_w_data (w_data),
    .o_rx_full        (full),
    .o_rx_empty       (empty),
    .o_rx_count       (count),
    .i_rx_r_en        (r_en),
    .o_rx_r_data      (r_data),
    .o_rx_r_valid     (r_valid),
    .o_rx_ok          (ok),
    .i_ovfl_clr       (ovfl_clr),
`ifdef RX_FIFO_WMARK_EN
    .i_wmark_lvl      (wmark_lvl),
    .o_rx_wmark       (wmark),
`endif
    .o_rx_ovfl        (ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic [127:0] wd;
    logic         re;
    logic         clr;
    logic         e_valid;
    logic [127:0] e_data;
    logic [2:0]   e_count;
    logic         e_full;
    logic         e_empty;
    logic         e_ok;
    logic         e_ovfl;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [127:0] m(input logic [15:0] id);
    return {id, 112'h0};
  endfunction

  task automatic add(input logic we, input logic [15:0] wid, input logic re, input logic clr,
                     input logic ev, input logic [15:0] eid, input logic [2:0] ec,
                     input logic ef, input logic ee, input logic eo, input logic eov);
    vec_t v;
    v.we = we; v.wd = m(wid); v.re = re; v.clr = clr;
    v.e_valid = ev; v.e_data = m(eid); v.e_count = ec;
    v.e_full = ef; v.e_empty = ee; v.e_ok = eo; v.e_ovfl = eov;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge pass, return 1 time unit after it.
  task automatic cyc(input logic we, input logic [127:0] wd, input logic re, input logic clr);
    w_en = we; w_data = wd; r_en = re; ovfl_clr = clr;
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; ovfl_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; w_en = 1'b0; w_data = '0; r_en = 1'b0; ovfl_clr = 1'b0;
`ifdef RX_FIFO_WMARK_EN
    wmark_lvl = '0;
`endif

    //   we  wid       re clr  valid eid      cnt full empty ok ovfl
    add(1, 16'h0001, 0, 0,   0, 16'h0000, 1, 0, 0, 1, 0);
    add(1, 16'h0005, 0, 0,   0, 16'h0000, 2, 0, 0, 1, 0);
    add(0, 16'h0000, 1, 0,   1, 16'h0001, 1, 0, 0, 0, 0);
    add(0, 16'h0000, 1, 0,   1, 16'h0005, 0, 0, 1, 0, 0);
    add(0, 16'h0000, 1, 0,   0, 16'h0005, 0, 0, 1, 0, 0);
    add(1, 16'h0110, 0, 0,   0, 16'h0005, 1, 0, 0, 1, 0);
    add(1, 16'h0111, 0, 0,   0, 16'h0005, 2, 0, 0, 1, 0);
    add(1, 16'h0112, 0, 0,   0, 16'h0005, 3, 0, 0, 1, 0);
    add(1, 16'h0113, 0, 0,   0, 16'h0005, 4, 1, 0, 1, 0);
    add(1, 16'h0114, 0, 0,   0, 16'h0005, 4, 1, 0, 0, 1);
    add(0, 16'h0000, 0, 1,   0, 16'h0005, 4, 1, 0, 0, 0);
    add(1, 16'h0115, 1, 0,   1, 16'h0110, 4, 1, 0, 1, 0);
    add(1, 16'h0116, 0, 1,   0, 16'h0110, 4, 1, 0, 0, 1);
    add(0, 16'h0000, 1, 0,   1, 16'h0111, 3, 0, 0, 0, 1);
    add(0, 16'h0000, 1, 0,   1, 16'h0112, 2, 0, 0, 0, 1);
    add(0, 16'h0000, 1, 0,   1, 16'h0113, 1, 0, 0, 0, 1);
    add(0, 16'h0000, 1, 0,   1, 16'h0115, 0, 0, 1, 0, 1);
    add(0, 16'h0000, 0, 1,   0, 16'h0115, 0, 0, 1, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", r_valid, 0);
    chk("rst_data", r_data, 0);
    chk("rst_ok", ok, 0);
    chk("rst_ovfl", ovfl, 0);
    rst_n = 1'b1;

    // Table-driven order / full / overflow / simultaneous vectors
    foreach (vecs[i]) begin
      cyc(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].clr);
      chk($sformatf("v%0d_valid", i), r_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_data", i),  r_data,  vecs[i].e_data);
      chk($sformatf("v%0d_count", i), count,   vecs[i].e_count);
      chk($sformatf("v%0d_full", i),  full,    vecs[i].e_full);
      chk($sformatf("v%0d_empty", i), empty,   vecs[i].e_empty);
      chk($sformatf("v%0d_ok", i),    ok,      vecs[i].e_ok);
      chk($sformatf("v%0d_ovfl", i),  ovfl,    vecs[i].e_ovfl);
    end

    // Wrap: 10 write/pop pairs across the pointer wrap
    for (int k = 0; k < 10; k++) begin
      cyc(1, m(16'h0300 + 16'(k)), 0, 0);
      chk($sformatf("wrap%0d_wcount", k), count, 1);
      cyc(0, '0, 1, 0);
      chk($sformatf("wrap%0d_valid", k), r_valid, 1);
      chk($sformatf("wrap%0d_data", k), r_data, m(16'h0300 + 16'(k)));
      chk($sformatf("wrap%0d_empty", k), empty, 1);
    end
    cyc(0, '0, 1, 0);
    chk("wrap_emptyrd_valid", r_valid, 0);
    chk("wrap_emptyrd_data", r_data, m(16'h0309));

    // Reset asserted mid-stream after two writes
    cyc(1, m(16'h0201), 0, 0);
    cyc(1, m(16'h0202), 0, 0);
    chk("pre_rst_count", count, 2);
    cyc(0, '0, 1, 0);
    chk("pre_rst_valid", r_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_empty", empty, 1);
    chk("async_rst_count", count, 0);
    chk("async_rst_valid", r_valid, 0);
    chk("async_rst_data", r_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, '0, 1, 0);
    chk("post_rst_valid", r_valid, 0);
    chk("post_rst_count", count, 0);
    chk("post_rst_empty", empty, 1);

`ifdef RX_FIFO_WMARK_EN
    // Watermark at level 3, then disabled with level 0
    wmark_lvl = 3'd3;
    cyc(1, m(16'h0401), 0, 0);
    chk("wm_c1", wmark, 0);
    cyc(1, m(16'h0402), 0, 0);
    chk("wm_c2", wmark, 0);
    cyc(1, m(16'h0403), 0, 0);
    chk("wm_c3", wmark, 1);
    cyc(0, '0, 1, 0);
    chk("wm_back2", wmark, 0);
    wmark_lvl = 3'd0;
    cyc(1, m(16'h0404), 0, 0);
    chk("wm_lvl0_c3", wmark, 0);
    cyc(1, m(16'h0405), 0, 0);
    chk("wm_lvl0_c4", wmark, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/can_rx_fifo.md
Name: can_rx_fifo

Overview:
- Receive message FIFO directly downstream of the CAN acceptance filter, in the i_sys_clk domain.
- Stores each accepted 128-bit RX message (ID word in bits [127:96]) written by the filter.
- Drives o_rx_full back to the filter's i_rx_full input.
- Provides a registered, pop-on-request read port to the register/host interface, plus count, sticky overflow and a message-received pulse.

Parameters:
- DEPTH, 64, number of 128-bit entries; power of two, >= 2.
- DATA_W, 128, message width; fixed at 128 in this design.
- ADDR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- i_sys_clk  in  1  system clock; all logic on its rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_w_en  in  1  write strobe from acceptance filter, one cycle per message.
- i_rx_fifo_w_data  in  DATA_W  message from acceptance filter.
- o_rx_full  out  1  count == DEPTH; feeds the filter's i_rx_full.
- o_rx_empty  out  1  count == 0.
- o_rx_count  out  ADDR_W+1  entries currently stored, 0..DEPTH.
- i_rx_r_en  in  1  read/pop request from register interface.
- o_rx_r_data  out  DATA_W  popped message, registered.
- o_rx_r_valid  out  1  one-cycle pulse; o_rx_r_data is valid.
- o_rx_ok  out  1  one-cycle pulse per accepted write.
- o_rx_ovfl  out  1  sticky: a write was dropped because the FIFO was full.
- i_ovfl_clr  in  1  clears o_rx_ovfl.
- i_wmark_lvl  in  ADDR_W+1  watermark threshold (RX_FIFO_WMARK_EN only).
- o_rx_wmark  out  1  watermark flag (RX_FIFO_WMARK_EN only).

Behaviour:
- Reset (i_reset=0, asynchronous): pointers = 0, count = 0, o_rx_empty = 1, o_rx_full = 0, o_rx_r_data = 0, o_rx_r_valid = 0, o_rx_ok = 0, o_rx_ovfl = 0, o_rx_wmark = 0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all entries and any pending read result.
- Read accept: rd_acc = i_rx_r_en & (count != 0). Same-cycle write data is never readable (no fall-through).
- Write accept: wr_acc = i_rx_w_en & ((count != DEPTH) | rd_acc).
  - Full with simultaneous read: both are accepted and count stays at DEPTH.
- Dropped write: i_rx_w_en & ~wr_acc.
  - Memory, pointers and count are unchanged.
  - o_rx_ovfl is set next cycle.
- On wr_acc: mem[wptr] <= data; wptr increments modulo DEPTH (natural wrap); o_rx_ok = 1 next cycle.
- On rd_acc: o_rx_r_data <= mem[rptr] and o_rx_r_valid = 1 on the next cycle (1-cycle read latency); rptr increments modulo DEPTH.
- Read while empty: ignored. o_rx_r_valid stays 0 and o_rx_r_data holds its last value.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither. Count never exceeds DEPTH or goes below 0.
- Flag timing: o_rx_full, o_rx_empty and o_rx_count are decoded from the registered count. They change the cycle after the causing event.
- o_rx_ovfl priority: set beats clear. Drop and i_ovfl_clr in the same cycle leave o_rx_ovfl = 1; i_ovfl_clr alone clears it next cycle.
- Write path handshake: the filter must not assert i_rx_w_en while o_rx_full = 1. The FIFO still guards against it via the drop/overflow path.
- Single-entry write then read: earliest read accept is the cycle after the write, because count is registered.

Optional Feature:
- Macro: RX_FIFO_WMARK_EN.
- Defined:
  - i_wmark_lvl and o_rx_wmark exist.
  - o_rx_wmark is registered: 1 when count >= i_wmark_lvl and i_wmark_lvl != 0, else 0.
  - It updates every cycle from the next-state count, so it is aligned with o_rx_count.
- Not defined:
  - Both ports are absent from the port list.
  - No comparator logic is synthesized.
  - All other behaviour is identical.

Test Plan (DEPTH=4 in bench):
- Reset: hold i_reset=0 mid-stream after 2 writes -> o_rx_empty=1, o_rx_count=0, o_rx_r_valid=0; next read returns nothing.
- Order: write 128'h0001_0000_..._0000 then 128'h0005_0000_..._0000, then pop twice -> o_rx_r_data is 0001_0000.. then 0005_0000.., each with o_rx_r_valid one cycle after i_rx_r_en; o_rx_ok pulses twice.
- Full/overflow: write 4 messages -> o_rx_full=1, o_rx_count=4. Write a 5th (0114_0000..) -> dropped and o_rx_ovfl=1. Pop 4 -> the 4 originals come out in order; 0114 never appears.
- Simultaneous read/write when full: count=4, assert i_rx_w_en and i_rx_r_en together -> oldest entry returned, new entry stored, count stays 4, o_rx_ovfl stays 0.
- Wrap and empty read: 10 write/pop pairs cross the pointer wrap with data intact. A pop while empty gives no o_rx_r_valid and o_rx_r_data unchanged. Drop and i_ovfl_clr together leave o_rx_ovfl=1.
- RX_FIFO_WMARK_EN: i_wmark_lvl=3 -> o_rx_wmark rises with count 3 and falls when count returns to 2. i_wmark_lvl=0 -> o_rx_wmark stays 0.
